// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory stack unit: FSM state encoding,
// SP reset value and the request-priority resolution.
package dm_pkg;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CALL_H  = 3'd1,
      ST_RET_H   = 3'd2,
      ST_RET_L   = 3'd3,
      ST_RET_OUT = 3'd4,
      ST_POP_OUT = 3'd5
   } dm_state_e;

   // SP reset value (top of data RAM)
   localparam logic [15:0] DM_SP_INIT = 16'h08FF;

   // Resolved request, listed from highest to lowest priority
   typedef enum logic [2:0] {
      REQ_NONE = 3'd0,
      REQ_CALL = 3'd1,
      REQ_RET  = 3'd2,
      REQ_PUSH = 3'd3,
      REQ_POP  = 3'd4
   } dm_req_e;

   // The core should raise one request at a time; if it does not,
   // call > ret > push > pop decides which one is serviced.
   function automatic dm_req_e dm_pick_req(input logic call, input logic ret,
                                           input logic push, input logic pop);
      if (call)      return REQ_CALL;
      else if (ret)  return REQ_RET;
      else if (push) return REQ_PUSH;
      else if (pop)  return REQ_POP;
      else           return REQ_NONE;
   endfunction

endpackage

// File: rtl/dm_sp_reg.sv
// Stack-pointer register: I/O byte writes to SPL/SPH plus the +/-1 updates
// driven by the stack sequencer. A stack update always beats an I/O write
// in the same cycle; the I/O write is simply lost.
module dm_sp_reg
   import dm_pkg::*;
#(
   parameter int          SP_W    = 16,
   parameter logic [15:0] SP_INIT = DM_SP_INIT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_inc,
   input  logic            i_dec,
   input  logic            i_io_we,
   input  logic            i_l_en,
   input  logic            i_h_en,
   input  logic [7:0]      i_wdata,
   output logic [SP_W-1:0] o_sp
);

   logic [SP_W-1:0] r_sp;
   logic [15:0]     w_cur16;
   logic [15:0]     w_io16;
   logic            w_io_wr;

   assign o_sp    = r_sp;
   assign w_io_wr = i_io_we & (i_l_en | i_h_en);

   // Merge the I/O byte(s) into a 16-bit view; bits at or above SP_W drop out on store
   always_comb begin
      w_cur16             = '0;
      w_cur16[SP_W-1:0]   = r_sp;
      w_io16              = w_cur16;
      if (i_io_we & i_l_en) w_io16[7:0]  = i_wdata;
      if (i_io_we & i_h_en) w_io16[15:8] = i_wdata;
   end

   // SP update: stack arithmetic first, otherwise I/O write, modulo 2^SP_W
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sp <= SP_INIT[SP_W-1:0];
      end else if (i_inc) begin
         r_sp <= r_sp + SP_W'(1);
      end else if (i_dec) begin
         r_sp <= r_sp - SP_W'(1);
      end else if (w_io_wr) begin
         r_sp <= w_io16[SP_W-1:0];
      end
   end

endmodule

// File: rtl/dm_stack_unit.sv
// Stack-access sequencer for the data-memory stage. Owns SPH:SPL via
// dm_sp_reg and turns PUSH/POP/CALL/RET into data-memory cycles.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | accept requests; PUSH completes here, others start here
// ST_CALL_H  | write return-address high byte at SP
// ST_RET_H   | capture high byte, read low byte at SP+1
// ST_RET_L   | capture low byte
// ST_RET_OUT | present ret_pc / ret_valid
// ST_POP_OUT | present pop_data / pop_valid
module dm_stack_unit
   import dm_pkg::*;
#(
   parameter int          SP_W    = 16,
   parameter logic [15:0] SP_INIT = DM_SP_INIT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sp_l_en,
   input  logic        sp_h_en,
   input  logic        io_we,
   input  logic [7:0]  io_wdata,
   output logic [7:0]  io_rdata,
   input  logic        push_req,
   input  logic [7:0]  push_data,
   input  logic        pop_req,
   input  logic        call_req,
   input  logic        ret_req,
   input  logic [15:0] pc_in,
   output logic        busy,
   output logic [7:0]  pop_data,
   output logic        pop_valid,
   output logic [15:0] ret_pc,
   output logic        ret_valid,
   output logic [15:0] dm_addr,
   output logic [7:0]  dm_wdata,
   output logic        dm_we,
   output logic        dm_re,
   input  logic [7:0]  dm_rdata
);

   dm_state_e       r_state;
   logic [7:0]      r_ret_hi;
   logic [7:0]      r_ret_lo;
   dm_req_e         w_req;
   logic [SP_W-1:0] w_sp;
   logic [SP_W-1:0] w_sp_p1;
   logic [15:0]     w_sp_ext;
   logic [15:0]     w_sp_p1_ext;
   logic            w_sp_inc;
   logic            w_sp_dec;
   logic            w_addr_p1;

   dm_sp_reg #(
      .SP_W    (SP_W),
      .SP_INIT (SP_INIT)
   ) u_sp_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (w_sp_inc),
      .i_dec   (w_sp_dec),
      .i_io_we (io_we),
      .i_l_en  (sp_l_en),
      .i_h_en  (sp_h_en),
      .i_wdata (io_wdata),
      .o_sp    (w_sp)
   );

   assign w_sp_p1 = w_sp + SP_W'(1);
   assign w_req   = dm_pick_req(call_req, ret_req, push_req, pop_req);
   assign busy    = (r_state != ST_IDLE);

   // Zero-extend SP and SP+1 to the 16-bit memory address space
   always_comb begin
      w_sp_ext                 = '0;
      w_sp_ext[SP_W-1:0]       = w_sp;
      w_sp_p1_ext              = '0;
      w_sp_p1_ext[SP_W-1:0]    = w_sp_p1;
   end

   // Memory cycle and SP step for the current state / request
   always_comb begin
      dm_we     = 1'b0;
      dm_re     = 1'b0;
      dm_wdata  = 8'h00;
      w_sp_inc  = 1'b0;
      w_sp_dec  = 1'b0;
      w_addr_p1 = 1'b0;
      case (r_state)
         ST_IDLE: begin
            case (w_req)
               REQ_CALL: begin
                  dm_we    = 1'b1;
                  dm_wdata = pc_in[7:0];
                  w_sp_dec = 1'b1;
               end
               REQ_PUSH: begin
                  dm_we    = 1'b1;
                  dm_wdata = push_data;
                  w_sp_dec = 1'b1;
               end
               REQ_RET, REQ_POP: begin
                  dm_re     = 1'b1;
                  w_addr_p1 = 1'b1;
                  w_sp_inc  = 1'b1;
               end
               default: ;
            endcase
         end
         ST_CALL_H: begin
            dm_we    = 1'b1;
            dm_wdata = pc_in[15:8];
            w_sp_dec = 1'b1;
         end
         ST_RET_H: begin
            dm_re     = 1'b1;
            w_addr_p1 = 1'b1;
            w_sp_inc  = 1'b1;
         end
         default: ;
      endcase
      dm_addr = w_addr_p1 ? w_sp_p1_ext : w_sp_ext;
   end

   // Sequencer state and its registered result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_ret_hi  <= 8'h00;
         r_ret_lo  <= 8'h00;
         pop_data  <= 8'h00;
         pop_valid <= 1'b0;
         ret_pc    <= 16'h0000;
         ret_valid <= 1'b0;
      end else begin
         pop_valid <= 1'b0;
         ret_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               case (w_req)
                  REQ_CALL: r_state <= ST_CALL_H;
                  REQ_RET:  r_state <= ST_RET_H;
                  REQ_POP:  r_state <= ST_POP_OUT;
                  default:  r_state <= ST_IDLE;
               endcase
            end
            ST_CALL_H: r_state <= ST_IDLE;
            ST_RET_H: begin
               r_ret_hi <= dm_rdata;
               r_state  <= ST_RET_L;
            end
            ST_RET_L: begin
               r_ret_lo <= dm_rdata;
               r_state  <= ST_RET_OUT;
            end
            ST_RET_OUT: begin
               ret_pc    <= {r_ret_hi, r_ret_lo};
               ret_valid <= 1'b1;
               r_state   <= ST_IDLE;
            end
            ST_POP_OUT: begin
               pop_data  <= dm_rdata;
               pop_valid <= 1'b1;
               r_state   <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Registered SPL/SPH read port; SPL wins if both are selected
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         io_rdata <= 8'h00;
      end else if (sp_l_en) begin
         io_rdata <= w_sp_ext[7:0];
      end else if (sp_h_en) begin
         io_rdata <= w_sp_ext[15:8];
      end else begin
         io_rdata <= 8'h00;
      end
   end

endmodule

// File: tb/tb_dm_stack_unit.sv
// Self-checking bench for dm_stack_unit: memory model, transaction and
// result scoreboards, and one task per scenario.
module tb_dm_stack_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sp_l_en, sp_h_en, io_we;
   logic [7:0]  io_wdata, io_rdata;
   logic        push_req, pop_req, call_req, ret_req;
   logic [7:0]  push_data;
   logic [15:0] pc_in;
   logic        busy;
   logic [7:0]  pop_data;
   logic        pop_valid;
   logic [15:0] ret_pc;
   logic        ret_valid;
   logic [15:0] dm_addr;
   logic [7:0]  dm_wdata;
   logic        dm_we, dm_re;
   logic [7:0]  dm_rdata;

   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  data;
   } txn_t;

   typedef struct packed {
      logic        is_ret;
      logic [15:0] val;
   } out_t;

   txn_t exp_txn[$];
   out_t exp_out[$];
   txn_t m_t;
   out_t m_o;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [15:0] m_sp;
   logic [7:0]  mem [0:65535];

   always #5 clk = ~clk;

   dm_stack_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sp_l_en   (sp_l_en),
      .sp_h_en   (sp_h_en),
      .io_we     (io_we),
      .io_wdata  (io_wdata),
      .io_rdata  (io_rdata),
      .push_req  (push_req),
      .push_data (push_data),
      .pop_req   (pop_req),
      .call_req  (call_req),
      .ret_req   (ret_req),
      .pc_in     (pc_in),
      .busy      (busy),
      .pop_data  (pop_data),
      .pop_valid (pop_valid),
      .ret_pc    (ret_pc),
      .ret_valid (ret_valid),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_we     (dm_we),
      .dm_re     (dm_re),
      .dm_rdata  (dm_rdata)
   );

   // Data memory: write on the edge, read data one cycle after dm_re
   always @(posedge clk) begin
      if (dm_we) mem[dm_addr] <= dm_wdata;
      if (dm_re) dm_rdata <= mem[dm_addr];
   end

   // Memory-cycle and result scoreboard, sampled mid-cycle
   always @(negedge clk) begin
      if (rst_n && (dm_we || dm_re)) begin
         n_checks++;
         if (exp_txn.size() == 0) begin
            n_fail++;
            $display("FAIL dm_txn: got unexpected we=%0b re=%0b addr=%h wdata=%h, required no cycle",
                     dm_we, dm_re, dm_addr, dm_wdata);
         end else begin
            m_t = exp_txn.pop_front();
            if (dm_we !== m_t.we || dm_re !== !m_t.we || dm_addr !== m_t.addr ||
                (m_t.we && dm_wdata !== m_t.data)) begin
               n_fail++;
               $display("FAIL dm_txn: got we=%0b re=%0b addr=%h wdata=%h, required we=%0b addr=%h wdata=%h",
                        dm_we, dm_re, dm_addr, dm_wdata, m_t.we, m_t.addr, m_t.data);
            end
         end
      end
      if (rst_n && (pop_valid || ret_valid)) begin
         n_checks++;
         if (exp_out.size() == 0) begin
            n_fail++;
            $display("FAIL result: got unexpected pop_valid=%0b ret_valid=%0b, required none",
                     pop_valid, ret_valid);
         end else begin
            m_o = exp_out.pop_front();
            if (m_o.is_ret ? (ret_valid !== 1'b1 || pop_valid !== 1'b0 || ret_pc !== m_o.val)
                           : (pop_valid !== 1'b1 || ret_valid !== 1'b0 || pop_data !== m_o.val[7:0])) begin
               n_fail++;
               $display("FAIL result: got pop_valid=%0b pop_data=%h ret_valid=%0b ret_pc=%h, required is_ret=%0b value=%h",
                        pop_valid, pop_data, ret_valid, ret_pc, m_o.is_ret, m_o.val);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1);
   end

   task automatic read_sp(output logic [15:0] v);
      sp_l_en = 1'b1;
      @(posedge clk); #1;
      v[7:0]  = io_rdata;
      sp_l_en = 1'b0;
      sp_h_en = 1'b1;
      @(posedge clk); #1;
      v[15:8] = io_rdata;
      sp_h_en = 1'b0;
   endtask

   task automatic io_write(input logic hi, input logic [7:0] d);
      io_we    = 1'b1;
      io_wdata = d;
      if (hi) sp_h_en = 1'b1; else sp_l_en = 1'b1;
      @(posedge clk); #1;
      io_we   = 1'b0;
      sp_h_en = 1'b0;
      sp_l_en = 1'b0;
      if (hi) m_sp[15:8] = d; else m_sp[7:0] = d;
   endtask

   task automatic set_sp(input logic [15:0] v);
      io_write(1'b0, v[7:0]);
      io_write(1'b1, v[15:8]);
   endtask

   task automatic do_push(input logic [7:0] d);
      push_req  = 1'b1;
      push_data = d;
      exp_txn.push_back({1'b1, m_sp, d});
      m_sp = m_sp - 16'd1;
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL push_busy: got %0b, required 0", busy);
      end
      push_req = 1'b0;
   endtask

   task automatic do_pop(input logic [7:0] d);
      logic [15:0] a;
      a = m_sp + 16'd1;
      pop_req = 1'b1;
      exp_txn.push_back({1'b0, a, 8'h00});
      exp_out.push_back({1'b0, 8'h00, d});
      m_sp = a;
      @(posedge clk); #1;
      pop_req = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || pop_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL pop_lat1: got busy=%0b pop_valid=%0b, required busy=1 pop_valid=0", busy, pop_valid);
      end
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b0 || pop_valid !== 1'b1 || pop_data !== d) begin
         n_fail++;
         $display("FAIL pop_lat2: got busy=%0b pop_valid=%0b data=%h, required busy=0 pop_valid=1 data=%h",
                  busy, pop_valid, pop_data, d);
      end
   endtask

   task automatic test_reset;
      logic [15:0] v;
      n_checks++;
      if (busy !== 1'b0 || dm_we !== 1'b0 || dm_re !== 1'b0 || pop_valid !== 1'b0 ||
          ret_valid !== 1'b0 || io_rdata !== 8'h00 || pop_data !== 8'h00 || ret_pc !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%0b we=%0b re=%0b pv=%0b rv=%0b io=%h pd=%h rp=%h, required all zero",
                  busy, dm_we, dm_re, pop_valid, ret_valid, io_rdata, pop_data, ret_pc);
      end
      read_sp(v);
      n_checks++;
      if (v !== 16'h08FF) begin
         n_fail++;
         $display("FAIL reset_sp: got %h, required 08ff", v);
      end
      @(posedge clk); #1;
      n_checks++;
      if (io_rdata !== 8'h00) begin
         n_fail++;
         $display("FAIL io_rdata_unselected: got %h, required 00", io_rdata);
      end
   endtask

   task automatic test_push_pop;
      logic [15:0] v;
      do_push(8'hA5);
      read_sp(v);
      n_checks++;
      if (v !== 16'h08FE) begin
         n_fail++;
         $display("FAIL push_sp: got %h, required 08fe", v);
      end
      do_pop(8'hA5);
      read_sp(v);
      n_checks++;
      if (v !== 16'h08FF) begin
         n_fail++;
         $display("FAIL pop_sp: got %h, required 08ff", v);
      end
   endtask

   task automatic test_call_ret;
      logic [15:0] v;
      set_sp(16'h0100);
      call_req = 1'b1;
      pc_in    = 16'h1234;
      exp_txn.push_back({1'b1, 16'h0100, 8'h34});
      exp_txn.push_back({1'b1, 16'h00FF, 8'h12});
      m_sp = 16'h00FE;
      @(posedge clk); #1;
      call_req = 1'b0;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL call_busy1: got %0b, required 1", busy);
      end
      @(posedge clk); #1;
      pc_in = 16'h0000;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL call_busy2: got %0b, required 0", busy);
      end
      read_sp(v);
      n_checks++;
      if (v !== 16'h00FE) begin
         n_fail++;
         $display("FAIL call_sp: got %h, required 00fe", v);
      end
      ret_req = 1'b1;
      exp_txn.push_back({1'b0, 16'h00FF, 8'h00});
      exp_txn.push_back({1'b0, 16'h0100, 8'h00});
      exp_out.push_back({1'b1, 16'h1234});
      m_sp = 16'h0100;
      @(posedge clk); #1;
      ret_req = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         n_checks++;
         if (busy !== 1'b1 || ret_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ret_busy_c%0d: got busy=%0b ret_valid=%0b, required busy=1 ret_valid=0",
                     i, busy, ret_valid);
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (busy !== 1'b0 || ret_valid !== 1'b1 || ret_pc !== 16'h1234) begin
         n_fail++;
         $display("FAIL ret_out: got busy=%0b ret_valid=%0b ret_pc=%h, required busy=0 ret_valid=1 ret_pc=1234",
                  busy, ret_valid, ret_pc);
      end
      read_sp(v);
      n_checks++;
      if (v !== 16'h0100) begin
         n_fail++;
         $display("FAIL ret_sp: got %h, required 0100", v);
      end
   endtask

   task automatic test_wrap;
      logic [15:0] v;
      set_sp(16'h0000);
      do_push(8'h3C);
      read_sp(v);
      n_checks++;
      if (v !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL wrap_push_sp: got %h, required ffff", v);
      end
      do_pop(8'h3C);
      read_sp(v);
      n_checks++;
      if (v !== 16'h0000) begin
         n_fail++;
         $display("FAIL wrap_pop_sp: got %h, required 0000", v);
      end
   endtask

   task automatic test_conflict;
      logic [15:0] v;
      set_sp(16'h0200);
      push_req  = 1'b1;
      push_data = 8'h77;
      io_we     = 1'b1;
      sp_l_en   = 1'b1;
      io_wdata  = 8'h55;
      exp_txn.push_back({1'b1, 16'h0200, 8'h77});
      m_sp = 16'h01FF;
      @(posedge clk); #1;
      push_req = 1'b0;
      io_we    = 1'b0;
      sp_l_en  = 1'b0;
      read_sp(v);
      n_checks++;
      if (v !== 16'h01FF) begin
         n_fail++;
         $display("FAIL conflict_sp: got %h, required 01ff", v);
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] v;
      logic [7:0]  vals [3];
      vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
      for (int i = 0; i < 3; i++) begin
         push_req  = 1'b1;
         push_data = vals[i];
         exp_txn.push_back({1'b1, m_sp, vals[i]});
         m_sp = m_sp - 16'd1;
         @(posedge clk); #1;
      end
      push_req = 1'b0;
      for (int i = 2; i >= 0; i--) begin
         m_sp = m_sp + 16'd1;
         exp_txn.push_back({1'b0, m_sp, 8'h00});
         exp_out.push_back({1'b0, 8'h00, vals[i]});
      end
      pop_req = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      pop_req = 1'b0;
      @(posedge clk); #1;
      read_sp(v);
      n_checks++;
      if (v !== 16'h01FF) begin
         n_fail++;
         $display("FAIL b2b_sp: got %h, required 01ff", v);
      end
   endtask

   task automatic test_priority;
      logic [15:0] v;
      call_req  = 1'b1;
      push_req  = 1'b1;
      push_data = 8'hEE;
      pc_in     = 16'hABCD;
      exp_txn.push_back({1'b1, 16'h01FF, 8'hCD});
      exp_txn.push_back({1'b1, 16'h01FE, 8'hAB});
      m_sp = 16'h01FD;
      @(posedge clk); #1;
      call_req = 1'b0;
      push_req = 1'b0;
      @(posedge clk); #1;
      pc_in = 16'h0000;
      read_sp(v);
      n_checks++;
      if (v !== 16'h01FD) begin
         n_fail++;
         $display("FAIL priority_sp: got %h, required 01fd", v);
      end
   endtask

   task automatic test_reset_mid_ret;
      logic [15:0] v;
      logic        seen;
      set_sp(16'h0300);
      ret_req = 1'b1;
      exp_txn.push_back({1'b0, 16'h0301, 8'h00});
      @(posedge clk); #1;
      ret_req = 1'b0;
      rst_n   = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || dm_re !== 1'b0 || ret_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL midret_reset: got busy=%0b dm_re=%0b ret_valid=%0b, required all 0",
                  busy, dm_re, ret_valid);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_sp  = 16'h08FF;
      seen  = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (ret_valid) seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL midret_no_valid: got ret_valid seen=%0b, required 0", seen);
      end
      read_sp(v);
      n_checks++;
      if (v !== 16'h08FF) begin
         n_fail++;
         $display("FAIL midret_sp: got %h, required 08ff", v);
      end
      do_push(8'h99);
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      sp_l_en   = 1'b0;
      sp_h_en   = 1'b0;
      io_we     = 1'b0;
      io_wdata  = 8'h00;
      push_req  = 1'b0;
      push_data = 8'h00;
      pop_req   = 1'b0;
      call_req  = 1'b0;
      ret_req   = 1'b0;
      pc_in     = 16'h0000;
      m_sp      = 16'h08FF;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      test_reset();
      test_push_pop();
      test_call_ret();
      test_wrap();
      test_conflict();
      test_back_to_back();
      test_priority();
      test_reset_mid_ret();

      n_checks++;
      if (exp_txn.size() != 0 || exp_out.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d cycles and %0d results outstanding, required 0 and 0",
                  exp_txn.size(), exp_out.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dm_stack_unit.md
# dm_stack_unit

Stack-pointer register and stack-access sequencer for the data-memory stage. It consumes the `sp_l_en`/`sp_h_en` strobes produced by the I/O-enable mask stage and owns SPH:SPL. It generates data-memory read/write cycles for PUSH, POP, CALL and RET, including the two-byte return-address transfers. It sits between the decode/execute control and the data-memory port.

## Interface
- `SP_W`, 16: stack pointer width (bits); only the low `SP_W` bits are stored.
- `SP_INIT`, 16'h08FF: SP reset value (RAMEND).
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `sp_l_en`  in  1: SPL selected (from I/O-enable mask).
- `sp_h_en`  in  1: SPH selected.
- `io_we`  in  1: I/O write strobe.
- `io_wdata`  in  8: I/O write data.
- `io_rdata`  out  8: SPL/SPH read data; 0 when neither is selected.
- `push_req`  in  1: push one byte.
- `push_data`  in  8: byte to push.
- `pop_req`  in  1: pop one byte.
- `call_req`  in  1: push a 16-bit return address.
- `ret_req`  in  1: pop a 16-bit return address.
- `pc_in`  in  16: return address to push.
- `busy`  out  1: sequencer not idle; no new request is accepted.
- `pop_data`  out  8: popped byte.
- `pop_valid`  out  1: `pop_data` valid (1-cycle pulse).
- `ret_pc`  out  16: popped return address.
- `ret_valid`  out  1: `ret_pc` valid (1-cycle pulse).
- `dm_addr`  out  16: data-memory address.
- `dm_wdata`  out  8: data-memory write data.
- `dm_we`  out  1: data-memory write.
- `dm_re`  out  1: data-memory read.
- `dm_rdata`  in  8: read data, valid one cycle after `dm_re`.

## Operation
- States: IDLE, CALL_H, RET_H, RET_L, RET_OUT, POP_OUT.
- Requests are sampled only in IDLE. At most one request is asserted per cycle; priority if violated: call > ret > push > pop.
- PUSH (IDLE): `dm_addr`=SP, `dm_wdata`=`push_data`, `dm_we`=1; SP←SP−1; stay IDLE.
- POP (IDLE): `dm_addr`=SP+1, `dm_re`=1; SP←SP+1; go to POP_OUT.
- POP_OUT: `pop_data`←`dm_rdata`, `pop_valid`=1; go to IDLE.
- CALL (IDLE): write `pc_in[7:0]` at SP; SP←SP−1; go to CALL_H.
- CALL_H: write `pc_in[15:8]` at SP; SP←SP−1; go to IDLE. `pc_in` must be held stable by the core.
- RET (IDLE): read SP+1; SP←SP+1; go to RET_H.
- RET_H: capture hi←`dm_rdata`; read SP+1; SP←SP+1; go to RET_L.
- RET_L: capture lo←`dm_rdata`; go to RET_OUT.
- RET_OUT: `ret_pc`={hi,lo}, `ret_valid`=1; go to IDLE.
- `busy`=1 in every state except IDLE.
- I/O write with `io_we`&`sp_l_en` sets SP[7:0]; with `io_we`&`sp_h_en` sets SP[15:8] (bits ≥`SP_W` discarded).
- Conflict rule: a stack SP update in the same cycle as an I/O SP write wins, and the I/O write is dropped.
- SP arithmetic is modulo 2^`SP_W`: 0−1 wraps to all-ones; all-ones+1 wraps to 0. No overflow flag.
- `dm_addr` is zero-extended from `SP_W` bits.

## Timing
- `dm_*` outputs are combinational from state, SP and request inputs. `pop_data`, `ret_pc`, `ret_valid`, `pop_valid`, `io_rdata` are registered.
- Latency from request cycle:
  - PUSH: 1 cycle, no busy.
  - POP: `pop_valid` at +2.
  - CALL: 2 cycles, busy for 1.
  - RET: `ret_valid` at +4, busy for 3.
- Reset values (asynchronous, including mid-sequence): SP=`SP_INIT`, state=IDLE, `busy`=0, `pop_valid`=`ret_valid`=0, `pop_data`=0, `ret_pc`=0, `io_rdata`=0, `dm_we`=`dm_re`=0. An interrupted CALL/RET leaves memory partially written; no recovery is provided.

## Structure
- Shared package `dm_pkg`: state encoding enum, `SP_INIT` default, request-priority constants.
- Sub-module `dm_sp_reg`: SP register with I/O byte writes, ±1 update and the conflict rule. The FSM and memory muxing live in the top module.

## Test plan
- Reset → SP=16'h08FF; I/O read of SPL returns 8'hFF, SPH returns 8'h08; `busy`=0.
- PUSH 8'hA5 at SP=16'h08FF → write 8'hA5 to 16'h08FF; SP=16'h08FE. Then POP → read at 16'h08FF; `pop_valid` two cycles later with 8'hA5; SP=16'h08FF.
- CALL `pc_in`=16'h1234 at SP=16'h0100 → 8'h34@16'h0100, 8'h12@16'h00FF; SP=16'h00FE. Then RET → `ret_valid` with 16'h1234 at +4; SP=16'h0100.
- I/O write SPL=8'h00, SPH=8'h00, then PUSH → write at 16'h0000; SP wraps to 16'hFFFF. POP → read at 16'h0000.
- PUSH in the same cycle as an SPL write of 8'h55 at SP=16'h0200 → SP=16'h01FF; the I/O write is dropped.
- Assert `rst_n` low during RET_H → immediately `busy`=0, SP=16'h08FF, no `ret_valid`; the next PUSH writes to 16'h08FF.
